serial_match_scheduler: RTL
===========================

# serial_match_scheduler

Time-shares one serial pattern-match engine between `N_REQ` word-producing requesters. It arbitrates round-robin, serializes the granted word MSB-first through the engine, and keeps a separate bit-history context per requester. A match that spans word boundaries is therefore still detected. It sits in front of the bit-stream detectors and reports individual hits plus a per-word summary.

## Interface
- `N_REQ`, 2 — number of requesters; must be ≥2.
- `W`, 8 — word width in bits.
- `PLEN`, 6 — pattern length; 2 ≤ `PLEN` ≤ 16.
- `PATTERN`, 6'b110011 — `PLEN`-bit pattern; the first-arriving bit is the MSB.
- `clk` in 1 — single clock; all logic rises on `posedge clk`.
- `rst` in 1 — synchronous, active-high reset.
- `req_valid` in `N_REQ` — bit i: requester i offers a word.
- `req_data` in `N_REQ*W` — word for requester i at `[i*W +: W]`.
- `req_ready` out `N_REQ` — one-hot grant; a word transfers when `req_valid[i]` and `req_ready[i]` are both high.
- `hit` out 1 — pattern completed on the current bit.
- `hit_id` out `$clog2(N_REQ)` — requester owning the hit.
- `hit_pos` out `$clog2(W)` — bit index within the word, 0 = MSB.
- `done_valid` out 1 — one-cycle pulse at the end of each word.
- `done_id` out `$clog2(N_REQ)` — requester whose word finished.
- `done_hits` out `$clog2(W+1)` — hit count for that word.

## Operation
- FSM states are `IDLE`, `SHIFT` and `DONE`.
- **`IDLE`**
  - If any `req_valid` is high, grant the first valid requester searching from `last_grant+1` modulo `N_REQ`.
  - `req_ready[g]=1` combinationally in this cycle only; `req_ready` is 0 in every other state.
  - Capture the word, load context g into the working history, set `last_grant=g`, clear the hit counter, then go to `SHIFT`.
  - If nothing is valid, stay in `IDLE`.
- **`SHIFT`**: runs for W cycles, k = 0..W-1, using bit b = word[W-1-k].
  - Window = {hist[PLEN-2:0], b}.
  - `hit=1` iff window == `PATTERN` and `hist_len` == PLEN-1.
  - `hist` shifts b in.
  - `hist_len` increments, saturating at PLEN-1.
  - On a hit, the counter increments.
  - After k = W-1, go to `DONE`.
- **`DONE`**: asserts `done_valid`, `done_id=g`, `done_hits` = counter, writes the working history back to context g, then goes to `IDLE`.
- Matches may overlap; there is no reset of the history after a hit.
- The `hist_len` guard means a match cannot be produced from reset-cleared history bits. This matters for patterns with leading zeros.
- Contexts of requesters that are not granted are never modified.
- `hit_id`/`hit_pos` are valid only when `hit=1` and are 0 otherwise. `done_id`/`done_hits` are 0 when `done_valid=0`.

## Timing
- Each word occupies 1 (`IDLE` grant) + W (`SHIFT`) + 1 (`DONE`) cycles. Sustained throughput is one word per W+2 cycles.
- `hit` for bit k is asserted in the k-th `SHIFT` cycle, i.e. grant cycle + 1 + k.
- `done_valid` is asserted in cycle grant + W + 1.
- The next grant occurs the cycle after `DONE` at the earliest.
- A requester must hold `req_valid`/`req_data` stable until it is granted. Dropping `req_valid` before the grant is allowed; that word is simply not taken.
- Reset, including mid-`SHIFT`:
  - The next state is `IDLE`.
  - `last_grant` = N_REQ-1, so the first grant searches from 0.
  - All contexts and `hist_len` are cleared.
  - All outputs are 0 in the cycle after `rst` is sampled high.
  - The word in flight is discarded with no `done_valid`.

## Configuration
- `SERIAL_MATCH_SCHED_CTX_EN` defined: per-requester history and `hist_len` are saved in `DONE` and restored at grant, so matches span word boundaries.
- Not defined:
  - The context storage is omitted.
  - The working history and `hist_len` are cleared at every grant, so only matches lying wholly within one word are reported.
  - All other behaviour is identical.

## Test plan
All scenarios use the defaults: W=8, PLEN=6, `PATTERN`=110011, `N_REQ`=2.
- **Single word:** req0 sends 8'b11001100 after reset.
  - Required: grant at cycle 0, one `hit` with `hit_pos`=5 at cycle 6, `done_hits`=1 and `done_id`=0 at cycle 9.
- **Cross-word match:** req0 sends 8'b00000110 then 8'b01110000.
  - Word 1: `done_hits`=0.
  - Word 2, with `_CTX_EN`: `hit_pos`=2 and `done_hits`=1.
  - Word 2, without `_CTX_EN`: `done_hits`=0.
- **Round-robin:** both requesters hold `req_valid` for 4 words each.
  - Grants alternate 0,1,0,1,…, spaced exactly 10 cycles apart.
  - With `_CTX_EN`: req0 sends the two scenario-2 words interleaved with req1 words 8'hFF; req0 still hits at word 2, `hit_pos`=2, so the contexts are shown to be independent.
- **Empty-history guard:** with `PATTERN`=6'b000000, req0 sends 8'h00 as the first word after reset.
  - Hits occur at `hit_pos` 5, 6 and 7 only; `done_hits`=3.
- **Reset mid-operation:** assert `rst` at `SHIFT` k=3 of req1's word.
  - Required: no `done_valid`, all outputs 0, and the next grant goes to req0.
  - A cross-word pattern split across the reset is not detected.

Source files
------------

// File: rtl/serial_match_scheduler.sv
// rtl/serial_match_scheduler.sv - round-robin time-shared serial pattern matcher
// Define SERIAL_MATCH_SCHED_CTX_EN to keep per-requester bit history across words.
module serial_match_scheduler #(
    parameter int N_REQ = 2,
    parameter int W = 8,
    parameter int PLEN = 6,
    parameter logic [PLEN-1:0] PATTERN = 6'b110011
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*W-1:0]         req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       hit,
    output logic [$clog2(N_REQ)-1:0]   hit_id,
    output logic [$clog2(W)-1:0]       hit_pos,
    output logic                       done_valid,
    output logic [$clog2(N_REQ)-1:0]   done_id,
    output logic [$clog2(W+1)-1:0]     done_hits
);
    localparam int IDW = $clog2(N_REQ);
    localparam int POSW = $clog2(W);
    localparam int CNTW = $clog2(W+1);
    localparam int LW = $clog2(PLEN);
    localparam int HW = PLEN - 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  gid;
    logic [W-1:0]    word;
    logic [POSW-1:0] k;
    logic [HW-1:0]   hist;
    logic [LW-1:0]   hist_len;
    logic [CNTW-1:0] cnt;

`ifdef SERIAL_MATCH_SCHED_CTX_EN
    logic [HW-1:0]   ctx_hist [N_REQ];
    logic [LW-1:0]   ctx_len [N_REQ];
`endif

    logic            sel_found;
    logic [IDW-1:0]  sel_id;
    logic [IDW-1:0]  idx;

    // Search starts one past the previous grant so every requester gets a turn.
    always_comb begin
        sel_found = 1'b0;
        sel_id = '0;
        idx = '0;
        for (int j = 1; j <= N_REQ; j++) begin
            idx = IDW'((int'(last_grant) + j) % N_REQ);
            if (!sel_found && req_valid[idx]) begin
                sel_found = 1'b1;
                sel_id = idx;
            end
        end
    end

    logic            bit_in;
    logic [PLEN-1:0] window;
    logic            match;

    assign bit_in = word[W-1];
    assign window = {hist, bit_in};
    // Only a full history can match, so cleared bits never count as pattern zeros.
    assign match = (window == PATTERN) && (hist_len == LW'(PLEN-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last_grant <= IDW'(N_REQ-1);
            gid <= '0;
            word <= '0;
            k <= '0;
            hist <= '0;
            hist_len <= '0;
            cnt <= '0;
`ifdef SERIAL_MATCH_SCHED_CTX_EN
            for (int i = 0; i < N_REQ; i++) begin
                ctx_hist[i] <= '0;
                ctx_len[i] <= '0;
            end
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        gid <= sel_id;
                        last_grant <= sel_id;
                        word <= req_data[int'(sel_id)*W +: W];
                        k <= '0;
                        cnt <= '0;
`ifdef SERIAL_MATCH_SCHED_CTX_EN
                        hist <= ctx_hist[sel_id];
                        hist_len <= ctx_len[sel_id];
`else
                        hist <= '0;
                        hist_len <= '0;
`endif
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    hist <= window[HW-1:0];
                    if (hist_len != LW'(PLEN-1)) begin
                        hist_len <= hist_len + 1'b1;
                    end
                    if (match) begin
                        cnt <= cnt + 1'b1;
                    end
                    word <= {word[W-2:0], 1'b0};
                    k <= k + 1'b1;
                    if (k == POSW'(W-1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
`ifdef SERIAL_MATCH_SCHED_CTX_EN
                    ctx_hist[gid] <= hist;
                    ctx_len[gid] <= hist_len;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE && !rst && sel_found) ?
                       ({{(N_REQ-1){1'b0}}, 1'b1} << sel_id) : '0;
    assign hit = (state == SHIFT) && match;
    assign hit_id = hit ? gid : '0;
    assign hit_pos = hit ? k : '0;
    assign done_valid = (state == DONE);
    assign done_id = done_valid ? gid : '0;
    assign done_hits = done_valid ? cnt : '0;
endmodule
